id_operand_interlock: RTL and testbench

- Decode-side end of the writeback and bypass-status interface in the blocking 5-stage LoongArch CPU.
- Contains the IF→ID pipeline register, the 32x32 general register file, and the RAW-hazard interlock.
- Consumes the WB register write bus and the {valid&gr_we, dest} status buses from EX/MEM/WB.
- Stalls ID until no older in-flight instruction targets a source register. There is no data forwarding. Source-register values go to the ID decode logic.

---
 rtl/id_operand_interlock_if.sv | 42 ++++
 rtl/id_operand_interlock.sv | 84 ++++++++
 tb/tb_id_operand_interlock.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand_interlock_if.sv
// Decode-stage bundle: IF->ID handshake, decoder source info, WB write bus and
// the per-stage {we, dest} status buses. The DUT uses the slave view.
interface id_operand_interlock_if #(
  parameter int FS_TO_DS_BUS_WD = 64,
  parameter int WS_TO_RF_BUS_WD = 38,
  parameter int FW_BUS_WD       = 6
);
  // Handshake: a transfer IF->ID happens on a clock edge where fs_to_ds_valid &
  // ds_allowin; ID->EX happens where ds_to_es_valid & es_allowin. Valid is never
  // withdrawn by ID while its instruction is held.
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       ds_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [31:0]                ds_pc;
  logic [31:0]                ds_inst;
  logic                       src1_used;
  logic                       src2_used;
  logic                       src2_is_rd;
  logic [31:0]                rj_value;
  logic [31:0]                rkd_value;
  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
  logic [FW_BUS_WD-1:0]       es_fw_bus;
  logic [FW_BUS_WD-1:0]       ms_fw_bus;
  logic [FW_BUS_WD-1:0]       ws_fw_bus;
  logic                       ds_stall;

  modport slave (
    input  fs_to_ds_valid, fs_to_ds_bus, es_allowin, src1_used, src2_used,
           src2_is_rd, ws_to_rf_bus, es_fw_bus, ms_fw_bus, ws_fw_bus,
    output ds_allowin, ds_to_es_valid, ds_pc, ds_inst, rj_value, rkd_value,
           ds_stall
  );

  modport master (
    output fs_to_ds_valid, fs_to_ds_bus, es_allowin, src1_used, src2_used,
           src2_is_rd, ws_to_rf_bus, es_fw_bus, ms_fw_bus, ws_fw_bus,
    input  ds_allowin, ds_to_es_valid, ds_pc, ds_inst, rj_value, rkd_value,
           ds_stall
  );
endinterface

// File: rtl/id_operand_interlock.sv
// ID stage: IF->ID pipeline register, 32x32 register file and a RAW interlock
// that holds ID while any in-flight EX/MEM/WB instruction writes a used source.
module id_operand_interlock (
  input logic                 clk,
  input logic                 reset,
  id_operand_interlock_if.slave ifc
);
  localparam int FS_TO_DS_BUS_WD = 64;

  logic                       ds_valid_q, ds_valid_d;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus_q, fs_to_ds_bus_d;
  logic [31:0]                rf_q [32];

  logic [31:0] inst;
  logic [4:0]  rd, rj, rk, src2_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        hit_es1, hit_es2, hit_ms1, hit_ms2, hit_ws1, hit_ws2;
  logic        ds_stall, ds_ready_go, ds_allowin;

  assign inst      = fs_to_ds_bus_q[31:0];
  assign rd        = inst[4:0];
  assign rj        = inst[9:5];
  assign rk        = inst[14:10];
  assign src2_addr = ifc.src2_is_rd ? rd : rk;

  assign {rf_we, rf_waddr, rf_wdata} = ifc.ws_to_rf_bus;
  assign rf_wen = rf_we & (rf_waddr != 5'd0);

  // A stage hits a source when it will write a nonzero register that this
  // instruction actually reads. WB counts too: the RF has no write bypass.
  function automatic logic fw_hit(input logic [5:0] fw, input logic used,
                                  input logic [4:0] src);
    return fw[5] & (fw[4:0] != 5'd0) & used & (fw[4:0] == src);
  endfunction

  always_comb begin
    hit_es1 = fw_hit(ifc.es_fw_bus, ifc.src1_used, rj);
    hit_es2 = fw_hit(ifc.es_fw_bus, ifc.src2_used, src2_addr);
    hit_ms1 = fw_hit(ifc.ms_fw_bus, ifc.src1_used, rj);
    hit_ms2 = fw_hit(ifc.ms_fw_bus, ifc.src2_used, src2_addr);
    hit_ws1 = fw_hit(ifc.ws_fw_bus, ifc.src1_used, rj);
    hit_ws2 = fw_hit(ifc.ws_fw_bus, ifc.src2_used, src2_addr);
  end

  assign ds_stall    = ds_valid_q & (hit_es1 | hit_es2 | hit_ms1 | hit_ms2 |
                                     hit_ws1 | hit_ws2);
  assign ds_ready_go = ~ds_stall;
  assign ds_allowin  = ~ds_valid_q | (ds_ready_go & ifc.es_allowin);

  always_comb begin
    ds_valid_d     = ds_valid_q;
    fs_to_ds_bus_d = fs_to_ds_bus_q;
    if (ds_allowin) begin
      ds_valid_d = ifc.fs_to_ds_valid;
      if (ifc.fs_to_ds_valid) fs_to_ds_bus_d = ifc.fs_to_ds_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q     <= 1'b0;
      fs_to_ds_bus_q <= '0;
    end else begin
      ds_valid_q     <= ds_valid_d;
      fs_to_ds_bus_q <= fs_to_ds_bus_d;
    end
  end

  // Register contents are architectural state and intentionally not reset.
  always_ff @(posedge clk) begin
    if (rf_wen) rf_q[rf_waddr] <= rf_wdata;
  end

  assign ifc.rj_value       = (rj == 5'd0) ? 32'd0 : rf_q[rj];
  assign ifc.rkd_value      = (src2_addr == 5'd0) ? 32'd0 : rf_q[src2_addr];
  assign ifc.ds_stall       = ds_stall;
  assign ifc.ds_allowin     = ds_allowin;
  assign ifc.ds_to_es_valid = ds_valid_q & ds_ready_go;
  assign ifc.ds_pc          = fs_to_ds_bus_q[63:32];
  assign ifc.ds_inst        = inst;
endmodule

// File: tb/tb_id_operand_interlock.sv
// Bench for id_operand_interlock: vector table, directed multi-cycle sequences
// and a randomized run against a behavioural model of the ID stage.
module tb_id_operand_interlock;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_operand_interlock_if ifc ();
  id_operand_interlock dut (.clk(clk), .reset(reset), .ifc(ifc));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rf_m [32];
  logic [31:0] exp_q [$];

  typedef struct {
    logic       s1, s2, s2rd;
    logic [4:0] rd, rj, rk;
    logic [5:0] es, ms, ws;
    logic       exp_stall;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rk, rj, rd);
    return {17'h0, rk, rj, rd};
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf_m[a];
  endfunction

  task automatic idle_inputs();
    ifc.fs_to_ds_valid = 1'b0;
    ifc.fs_to_ds_bus   = '0;
    ifc.es_allowin     = 1'b1;
    ifc.src1_used      = 1'b0;
    ifc.src2_used      = 1'b0;
    ifc.src2_is_rd     = 1'b0;
    ifc.ws_to_rf_bus   = '0;
    ifc.es_fw_bus      = '0;
    ifc.ms_fw_bus      = '0;
    ifc.ws_fw_bus      = '0;
  endtask

  task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
    ifc.fs_to_ds_valid = 1'b1;
    ifc.fs_to_ds_bus   = {pc, inst};
    ifc.es_allowin     = 1'b1;
    ifc.es_fw_bus = '0; ifc.ms_fw_bus = '0; ifc.ws_fw_bus = '0;
    tick();
    ifc.fs_to_ds_valid = 1'b0;
  endtask

  // Behavioural model state for the randomized run.
  logic        m_valid;
  logic [31:0] m_pc, m_inst;

  function automatic logic model_stall(input logic [31:0] inst, input logic s1,
      input logic s2, input logic s2rd, input logic [5:0] es, ms, ws);
    logic [5:0] stages [3];
    logic       used [2];
    logic [4:0] addr [2];
    logic       any;
    stages[0] = es; stages[1] = ms; stages[2] = ws;
    used[0] = s1; addr[0] = inst[9:5];
    used[1] = s2; addr[1] = s2rd ? inst[4:0] : inst[14:10];
    any = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 2; k++)
        if (stages[s][5] && stages[s][4:0] != 0 && used[k] && stages[s][4:0] == addr[k])
          any = 1'b1;
    return any;
  endfunction

  initial begin
    idle_inputs();
    // Reset state
    repeat (3) tick();
    settle();
    chk("reset_valid", {31'd0, ifc.ds_to_es_valid}, 32'd0);
    chk("reset_allowin", {31'd0, ifc.ds_allowin}, 32'd1);
    chk("reset_stall", {31'd0, ifc.ds_stall}, 32'd0);
    chk("reset_pc", ifc.ds_pc, 32'd0);
    chk("reset_inst", ifc.ds_inst, 32'd0);
    reset = 1'b0;
    tick();

    // Preload every register, then an r0 write which must be ignored.
    for (int i = 1; i < 32; i++) begin
      rf_m[i] = (i == 5) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
      ifc.ws_to_rf_bus = {1'b1, 5'(i), rf_m[i]};
      tick();
    end
    rf_m[0] = 32'd0;
    ifc.ws_to_rf_bus = {1'b1, 5'd0, 32'hFFFF_FFFF};
    tick();
    ifc.ws_to_rf_bus = '0;

    // Vector table: {s1, s2, s2rd, rd, rj, rk, es, ms, ws, stall}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 6'h00, 6'h00, 6'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, {1'b1, 5'd0}, 6'h00, 6'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, {1'b1, 5'd4}, 6'h00, 6'h00, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, {1'b0, 5'd4}, 6'h00, 6'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, {1'b1, 5'd4}, 6'h00, 6'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd3, 6'h00, {1'b1, 5'd9}, 6'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 5'd3, 6'h00, {1'b1, 5'd9}, 6'h00, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 6'h00, 6'h00, {1'b1, 5'd3}, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd6, 5'd8, 6'h00, {1'b1, 5'd8}, 6'h00, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd6, 5'd8, {1'b1, 5'd7}, {1'b1, 5'd2}, {1'b1, 5'd1}, 1'b0};

    for (int v = 0; v < 10; v++) begin
      load_inst(32'h1c00_1000 + 32'(v * 4), mk_inst(vecs[v].rk, vecs[v].rj, vecs[v].rd));
      ifc.src1_used  = vecs[v].s1;
      ifc.src2_used  = vecs[v].s2;
      ifc.src2_is_rd = vecs[v].s2rd;
      ifc.es_fw_bus  = vecs[v].es;
      ifc.ms_fw_bus  = vecs[v].ms;
      ifc.ws_fw_bus  = vecs[v].ws;
      settle();
      chk($sformatf("vec%0d_stall", v), {31'd0, ifc.ds_stall}, {31'd0, vecs[v].exp_stall});
      chk($sformatf("vec%0d_valid", v), {31'd0, ifc.ds_to_es_valid}, {31'd0, ~vecs[v].exp_stall});
      chk($sformatf("vec%0d_allowin", v), {31'd0, ifc.ds_allowin}, {31'd0, ~vecs[v].exp_stall});
      if (!vecs[v].exp_stall) begin
        chk($sformatf("vec%0d_rj", v), ifc.rj_value, rd_m(vecs[v].rj));
        chk($sformatf("vec%0d_rkd", v), ifc.rkd_value,
            rd_m(vecs[v].s2rd ? vecs[v].rd : vecs[v].rk));
      end
      tick();
    end
    idle_inputs();
    tick();

    // Producer of r7 walks EX -> MEM -> WB; stall lasts exactly three cycles.
    load_inst(32'h1c00_2000, mk_inst(5'd7, 5'd0, 5'd0));
    ifc.src2_used = 1'b1;
    ifc.src2_is_rd = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ifc.es_fw_bus = (c == 0) ? {1'b1, 5'd7} : 6'h00;
      ifc.ms_fw_bus = (c == 1) ? {1'b1, 5'd7} : 6'h00;
      ifc.ws_fw_bus = (c == 2) ? {1'b1, 5'd7} : 6'h00;
      ifc.ws_to_rf_bus = (c == 2) ? {1'b1, 5'd7, 32'h0000_A5A5} : '0;
      settle();
      chk($sformatf("raw_stall_c%0d", c), {31'd0, ifc.ds_stall}, 32'd1);
      chk($sformatf("raw_allowin_c%0d", c), {31'd0, ifc.ds_allowin}, 32'd0);
      chk($sformatf("raw_pc_c%0d", c), ifc.ds_pc, 32'h1c00_2000);
      tick();
    end
    rf_m[7] = 32'h0000_A5A5;
    ifc.ws_fw_bus = '0;
    ifc.ws_to_rf_bus = '0;
    settle();
    chk("raw_clear_stall", {31'd0, ifc.ds_stall}, 32'd0);
    chk("raw_clear_valid", {31'd0, ifc.ds_to_es_valid}, 32'd1);
    chk("raw_new_value", ifc.rkd_value, 32'h0000_A5A5);
    tick();
    idle_inputs();
    tick();

    // Stream of four independent instructions, EX blocked for two cycles.
    begin
      int idx;
      idx = 0;
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h1c00_0000 + 32'(k * 4));
      for (int cyc = 0; cyc < 20; cyc++) begin
        logic fire_fs;
        ifc.fs_to_ds_valid = (idx < 4);
        ifc.fs_to_ds_bus   = {32'h1c00_0000 + 32'(idx * 4), mk_inst(5'd1, 5'd2, 5'd3)};
        ifc.es_allowin     = !(cyc == 2 || cyc == 3);
        settle();
        if (cyc == 2 || cyc == 3)
          chk($sformatf("blocked_valid_c%0d", cyc), {31'd0, ifc.ds_to_es_valid}, 32'd1);
        fire_fs = ifc.fs_to_ds_valid & ifc.ds_allowin;
        if (ifc.ds_to_es_valid && ifc.es_allowin) begin
          if (exp_q.size() == 0) chk("stream_extra_issue", ifc.ds_pc, 32'hFFFF_FFFF);
          else chk("stream_pc", ifc.ds_pc, exp_q.pop_front());
        end
        tick();
        if (fire_fs) idx++;
      end
      chk("stream_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    idle_inputs();
    tick();

    // Reset while stalled.
    load_inst(32'h1c00_3000, mk_inst(5'd0, 5'd3, 5'd0));
    ifc.src1_used = 1'b1;
    ifc.es_fw_bus = {1'b1, 5'd3};
    settle();
    chk("pre_reset_stall", {31'd0, ifc.ds_stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("mid_reset_valid", {31'd0, ifc.ds_to_es_valid}, 32'd0);
    chk("mid_reset_stall", {31'd0, ifc.ds_stall}, 32'd0);
    chk("mid_reset_allowin", {31'd0, ifc.ds_allowin}, 32'd1);
    chk("mid_reset_pc", ifc.ds_pc, 32'd0);
    idle_inputs();
    tick();

    // Randomized run against the behavioural model.
    m_valid = 1'b0; m_pc = 32'd0; m_inst = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] r, data, inst;
      logic        m_stall, m_allow, m_go;
      r = $urandom;
      inst = {r[31:15], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7))};
      data = $urandom;
      ifc.fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      ifc.fs_to_ds_bus   = {32'h1c00_0000 + 32'(cyc * 4), inst};
      ifc.es_allowin     = ($urandom_range(0, 3) != 0);
      ifc.src1_used      = 1'($urandom_range(0, 1));
      ifc.src2_used      = 1'($urandom_range(0, 1));
      ifc.src2_is_rd     = 1'($urandom_range(0, 1));
      ifc.es_fw_bus      = {($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7))};
      ifc.ms_fw_bus      = {($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7))};
      ifc.ws_fw_bus      = {($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7))};
      ifc.ws_to_rf_bus   = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), data};
      settle();
      m_stall = m_valid & model_stall(m_inst, ifc.src1_used, ifc.src2_used,
                                      ifc.src2_is_rd, ifc.es_fw_bus, ifc.ms_fw_bus,
                                      ifc.ws_fw_bus);
      m_go    = m_valid & ~m_stall;
      m_allow = ~m_valid | (~m_stall & ifc.es_allowin);
      chk("rnd_stall", {31'd0, ifc.ds_stall}, {31'd0, m_stall});
      chk("rnd_valid", {31'd0, ifc.ds_to_es_valid}, {31'd0, m_go});
      chk("rnd_allowin", {31'd0, ifc.ds_allowin}, {31'd0, m_allow});
      chk("rnd_pc", ifc.ds_pc, m_pc);
      chk("rnd_inst", ifc.ds_inst, m_inst);
      if (m_go) begin
        chk("rnd_rj", ifc.rj_value, rd_m(m_inst[9:5]));
        chk("rnd_rkd", ifc.rkd_value, rd_m(ifc.src2_is_rd ? m_inst[4:0] : m_inst[14:10]));
      end
      tick();
      if (ifc.ws_to_rf_bus[37] && ifc.ws_to_rf_bus[36:32] != 5'd0)
        rf_m[ifc.ws_to_rf_bus[36:32]] = ifc.ws_to_rf_bus[31:0];
      if (m_allow) begin
        m_valid = ifc.fs_to_ds_valid;
        if (ifc.fs_to_ds_valid) begin
          m_pc   = ifc.fs_to_ds_bus[63:32];
          m_inst = ifc.fs_to_ds_bus[31:0];
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
